// File: rtl/pulse_maker_pkg.sv
// -----------------------------------------------------------------------------
// pulse_maker_pkg
// Shared definitions for the multi-channel pulse generator:
//   - pm_state_e        : per-channel FSM state encoding (2 bits)
//   - PM_CNT_W_DEFAULT  : default width of the delay/width counters
// No ports; imported by pulse_channel and pulse_maker_multi.
// -----------------------------------------------------------------------------
package pulse_maker_pkg;

  // Default width of the per-channel delay and width counts.
  localparam int PM_CNT_W_DEFAULT = 8;

  // Channel FSM states. The encoding is fixed so that debug tooling and
  // any downstream state taps see stable values.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } pm_state_e;

endpackage : pulse_maker_pkg

// File: rtl/pulse_channel.sv
// -----------------------------------------------------------------------------
// pulse_channel
// One independent pulse channel: edge detector, IDLE/DELAY/PULSE FSM with a
// down-counter, and a negedge-registered pulse output (active high here; the
// top level applies the output polarity).
//
// Ports:
//   clk          clock
//   reset        synchronous, active-low reset
//   in_i         trigger input, synchronous to clk
//   trig_rise_i  1 = trigger on rising edge, 0 = on falling edge
//   retrig_i     1 = an edge while busy restarts the channel, 0 = ignore it
//   delay_i      delay in clk cycles, captured on an accepted edge
//   width_i      pulse width in clk cycles, captured on an accepted edge
//   pulse_o      active-high pulse, registered on the negedge of clk
//   busy_o       high while the channel is not IDLE (posedge-registered)
//   overrun_o    one-cycle strobe when an edge is ignored (posedge-registered)
// -----------------------------------------------------------------------------
module pulse_channel
  import pulse_maker_pkg::*;
#(
  parameter int CNT_W = PM_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_i,
  input  logic             trig_rise_i,
  input  logic             retrig_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] width_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             in_q;
  pm_state_e        state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] width_q,   width_d;
  logic             overrun_q, overrun_d;
  logic             busy_q;
  logic             pulse_q;

  logic             edge_s;
  logic             load_s;

  // An edge is the input now sitting at the selected level while the value
  // sampled on the previous posedge sat at the opposite level.
  assign edge_s = (in_i == trig_rise_i) && (in_q != trig_rise_i);

  // A fresh capture happens on any edge from IDLE, or on any edge while busy
  // when retriggering is enabled. This includes the cycle the channel is
  // about to drop back to IDLE, since state_q still shows DELAY/PULSE then.
  assign load_s = edge_s && ((state_q == IDLE) || retrig_i);

  // Next-state, counter and strobe logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    width_d   = width_q;
    overrun_d = 1'b0;

    if (load_s) begin
      // Width is kept for the DELAY->PULSE hand-over; delay is only needed now.
      width_d = width_i;
      if (delay_i != CNT_ZERO) begin
        state_d = DELAY;
        cnt_d   = delay_i - CNT_ONE;
      end else if (width_i != CNT_ZERO) begin
        state_d = PULSE;
        cnt_d   = width_i - CNT_ONE;
      end else begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    end else begin
      // An edge that is not loaded can only be one seen while busy.
      overrun_d = edge_s && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
        DELAY: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (width_q != CNT_ZERO) begin
            state_d = PULSE;
            cnt_d   = width_q - CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end
        end
        PULSE: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Posedge state: input history, FSM, counter, captured width and strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // Track the input during reset so release never fakes an edge.
      in_q      <= in_i;
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      width_q   <= CNT_ZERO;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      in_q      <= in_i;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      overrun_q <= overrun_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  // Negedge output flop: half a cycle after the state update, so the pulse
  // starts at negedge k+delay and lasts exactly width periods.
  always_ff @(negedge clk) begin
    if (!reset) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= (state_q == PULSE);
    end
  end

  assign pulse_o   = pulse_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule : pulse_channel

// File: rtl/pulse_maker_multi.sv
// -----------------------------------------------------------------------------
// pulse_maker_multi
// CHANNELS independent delayed-pulse generators. Each channel waits for a
// selected edge on its trigger, counts out a delay, then drives a pulse of a
// programmed width. This level only slices the packed buses per channel and
// applies the output polarity.
//
// Parameters:
//   CHANNELS        number of channels
//   CNT_W           width of the delay/width counts
//   OUT_ACTIVE_LOW  1 = out idles high and pulses low, 0 = inverted
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   in         [CHANNELS]        trigger inputs
//   trig_rise  [CHANNELS]        1 = rising edge, 0 = falling edge
//   retrig     [CHANNELS]        1 = restart on new edge, 0 = ignore it
//   delay      [CHANNELS*CNT_W]  per-channel delay, channel i at [i*CNT_W +: CNT_W]
//   width      [CHANNELS*CNT_W]  per-channel width, same packing
//   out        [CHANNELS]        pulse outputs (negedge-registered)
//   busy       [CHANNELS]        channel not IDLE
//   overrun    [CHANNELS]        one-cycle strobe on an ignored edge
// -----------------------------------------------------------------------------
module pulse_maker_multi
  import pulse_maker_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = PM_CNT_W_DEFAULT,
  parameter int OUT_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in,
  input  logic [CHANNELS-1:0]       trig_rise,
  input  logic [CHANNELS-1:0]       retrig,
  input  logic [CHANNELS*CNT_W-1:0] delay,
  input  logic [CHANNELS*CNT_W-1:0] width,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       overrun
);

  logic [CHANNELS-1:0] pulse_s;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pulse_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk         (clk),
        .reset       (reset),
        .in_i        (in[i]),
        .trig_rise_i (trig_rise[i]),
        .retrig_i    (retrig[i]),
        .delay_i     (delay[i*CNT_W +: CNT_W]),
        .width_i     (width[i*CNT_W +: CNT_W]),
        .pulse_o     (pulse_s[i]),
        .busy_o      (busy[i]),
        .overrun_o   (overrun[i])
      );
    end
  endgenerate

  // Polarity is a constant inversion of the negedge flops, so out stays
  // glitch-free and effectively registered.
  assign out = (OUT_ACTIVE_LOW != 0) ? ~pulse_s : pulse_s;

endmodule : pulse_maker_multi

// File: tb/tb_pulse_maker_multi.sv
// -----------------------------------------------------------------------------
// tb_pulse_maker_multi
// Self-checking bench for pulse_maker_multi (4 channels, 8-bit counts,
// active-low outputs). The reference model describes each accepted trigger
// as a window in absolute cycle numbers: accepted at cycle k, pulse covers
// cycles [k+delay, k+delay+width), busy covers [k, k+delay+width).
// -----------------------------------------------------------------------------
module tb_pulse_maker_multi;

  localparam int CH = 4;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [CH-1:0]    in_s;
  logic [CH-1:0]    trig_rise_s;
  logic [CH-1:0]    retrig_s;
  logic [CH*CW-1:0] delay_s;
  logic [CH*CW-1:0] width_s;
  logic [CH-1:0]    out_s;
  logic [CH-1:0]    busy_s;
  logic [CH-1:0]    overrun_s;

  always #5 clk = ~clk;

  pulse_maker_multi #(
    .CHANNELS       (CH),
    .CNT_W          (CW),
    .OUT_ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_s),
    .trig_rise (trig_rise_s),
    .retrig    (retrig_s),
    .delay     (delay_s),
    .width     (width_s),
    .out       (out_s),
    .busy      (busy_s),
    .overrun   (overrun_s)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: window of the last accepted trigger per channel.
  longint cyc = 0;
  longint acc_c [CH];
  longint st_c  [CH];
  longint en_c  [CH];
  bit     prev_in [CH];

  // Per-scenario observations of the DUT.
  int     lo_cnt   [CH];
  int     busy_cnt [CH];
  int     ovr_cnt  [CH];
  longint first_lo [CH];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_obs();
    for (int c = 0; c < CH; c++) begin
      lo_cnt[c]   = 0;
      busy_cnt[c] = 0;
      ovr_cnt[c]  = 0;
      first_lo[c] = -1;
    end
  endtask

  // One clock cycle: model the posedge, check busy/overrun, then check out.
  task automatic step();
    logic [CH-1:0] exp_busy;
    logic [CH-1:0] exp_ovr;
    logic [CH-1:0] exp_out;
    bit            e;
    longint        d;
    longint        w;
    @(posedge clk);
    cyc++;
    exp_ovr = '0;
    for (int c = 0; c < CH; c++) begin
      if (!reset) begin
        acc_c[c] = -1;
        st_c[c]  = -1;
        en_c[c]  = -1;
      end else begin
        e = trig_rise_s[c] ? (!prev_in[c] && in_s[c]) : (prev_in[c] && !in_s[c]);
        if (e) begin
          if ((acc_c[c] < cyc) && (cyc <= en_c[c]) && !retrig_s[c]) begin
            exp_ovr[c] = 1'b1;
          end else begin
            d        = longint'(delay_s[c*CW +: CW]);
            w        = longint'(width_s[c*CW +: CW]);
            acc_c[c] = cyc;
            st_c[c]  = cyc + d;
            en_c[c]  = cyc + d + w;
          end
        end
      end
      prev_in[c]  = in_s[c];
      exp_busy[c] = (acc_c[c] <= cyc) && (cyc < en_c[c]);
    end
    #1;
    check_eq("busy", 64'(busy_s), 64'(exp_busy));
    check_eq("overrun", 64'(overrun_s), 64'(exp_ovr));
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      exp_out[c] = !(reset && (st_c[c] <= cyc) && (cyc < en_c[c]));
    end
    #1;
    check_eq("out", 64'(out_s), 64'(exp_out));
    for (int c = 0; c < CH; c++) begin
      if (out_s[c] === 1'b0) begin
        lo_cnt[c]++;
        if (first_lo[c] < 0) first_lo[c] = cyc;
      end
      if (busy_s[c] === 1'b1) busy_cnt[c]++;
      if (overrun_s[c] === 1'b1) ovr_cnt[c]++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic cfg(input int c, input int d, input int w, input bit rise, input bit rt);
    delay_s[c*CW +: CW] = d[CW-1:0];
    width_s[c*CW +: CW] = w[CW-1:0];
    trig_rise_s[c]      = rise;
    retrig_s[c]         = rt;
  endtask

  longint k;

  initial begin
    reset       = 1'b0;
    in_s        = '0;
    trig_rise_s = '1;
    retrig_s    = '0;
    delay_s     = '0;
    width_s     = '0;
    clear_obs();

    // Reset state: all quiet while reset is low.
    run(3);
    check_eq("rst_busy", 64'(busy_s), 64'd0);
    check_eq("rst_out", 64'(out_s), 64'hF);
    reset = 1'b1;
    run(2);

    // ch0 falling edge, delay 1, width 3.
    cfg(0, 1, 3, 1'b0, 1'b0);
    in_s[0] = 1'b1;
    run(2);
    clear_obs();
    k = cyc + 1;
    in_s[0] = 1'b0;
    run(10);
    check_eq("s1_first", 64'(first_lo[0]), 64'(k + 1));
    check_eq("s1_len", 64'(lo_cnt[0]), 64'd3);
    check_eq("s1_busy", 64'(busy_cnt[0]), 64'd4);

    // ch1 rising edge, delay 0, width 1; then delay 0, width 0.
    cfg(1, 0, 1, 1'b1, 1'b0);
    clear_obs();
    k = cyc + 1;
    in_s[1] = 1'b1;
    run(4);
    check_eq("s2_first", 64'(first_lo[1]), 64'(k));
    check_eq("s2_len", 64'(lo_cnt[1]), 64'd1);
    in_s[1] = 1'b0;
    cfg(1, 0, 0, 1'b1, 1'b0);
    run(2);
    clear_obs();
    in_s[1] = 1'b1;
    run(4);
    check_eq("s2_zero_len", 64'(lo_cnt[1]), 64'd0);
    check_eq("s2_zero_busy", 64'(busy_cnt[1]), 64'd0);

    // ch2 second edge while busy, retrig 0 then retrig 1.
    for (int rt = 0; rt < 2; rt++) begin
      cfg(2, 4, 2, 1'b1, rt[0]);
      in_s[2] = 1'b0;
      run(3);
      clear_obs();
      k = cyc + 1;
      in_s[2] = 1'b1;
      step();
      in_s[2] = 1'b0;
      step();
      in_s[2] = 1'b1;
      run(12);
      check_eq(rt == 0 ? "s3_ovr" : "s4_ovr", 64'(ovr_cnt[2]), rt == 0 ? 64'd1 : 64'd0);
      check_eq(rt == 0 ? "s3_first" : "s4_first", 64'(first_lo[2]), 64'(rt == 0 ? k + 4 : k + 6));
      check_eq(rt == 0 ? "s3_len" : "s4_len", 64'(lo_cnt[2]), 64'd2);
    end

    // ch3 reset in the middle of a 10-cycle pulse.
    cfg(3, 0, 10, 1'b1, 1'b0);
    in_s[3] = 1'b0;
    run(2);
    clear_obs();
    in_s[3] = 1'b1;
    run(3);
    reset = 1'b0;
    run(2);
    reset = 1'b1;
    run(15);
    check_eq("s5_len", 64'(lo_cnt[3]), 64'd3);
    check_eq("s5_busy", 64'(busy_cnt[3]), 64'd3);

    // All channels on one posedge; delays/widths changed mid-DELAY.
    in_s = '0;
    cfg(0, 1, 2, 1'b1, 1'b0);
    cfg(1, 2, 3, 1'b1, 1'b0);
    cfg(2, 3, 1, 1'b1, 1'b0);
    cfg(3, 5, 4, 1'b1, 1'b0);
    run(3);
    clear_obs();
    k = cyc + 1;
    in_s = '1;
    run(2);
    delay_s = '0;
    width_s = {CH{8'd9}};
    run(15);
    check_eq("s6_first0", 64'(first_lo[0]), 64'(k + 1));
    check_eq("s6_first1", 64'(first_lo[1]), 64'(k + 2));
    check_eq("s6_first2", 64'(first_lo[2]), 64'(k + 3));
    check_eq("s6_first3", 64'(first_lo[3]), 64'(k + 5));
    check_eq("s6_len0", 64'(lo_cnt[0]), 64'd2);
    check_eq("s6_len1", 64'(lo_cnt[1]), 64'd3);
    check_eq("s6_len2", 64'(lo_cnt[2]), 64'd1);
    check_eq("s6_len3", 64'(lo_cnt[3]), 64'd4);

    // Maximum delay and width on ch0.
    cfg(0, 255, 255, 1'b1, 1'b0);
    in_s[0] = 1'b0;
    run(2);
    clear_obs();
    k = cyc + 1;
    in_s[0] = 1'b1;
    run(515);
    check_eq("max_first", 64'(first_lo[0]), 64'(k + 255));
    check_eq("max_len", 64'(lo_cnt[0]), 64'd255);
    check_eq("max_busy", 64'(busy_cnt[0]), 64'd510);

    // Randomized traffic against the window model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(149) != 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(4) == 0) in_s[c] = ~in_s[c];
        if ($urandom_range(40) == 0) trig_rise_s[c] = ~trig_rise_s[c];
        if ($urandom_range(7) == 0) retrig_s[c] = ~retrig_s[c];
        if ($urandom_range(3) == 0) delay_s[c*CW +: CW] = 8'($urandom_range(6));
        if ($urandom_range(3) == 0) width_s[c*CW +: CW] = 8'($urandom_range(6));
        if ($urandom_range(60) == 0) width_s[c*CW +: CW] = 8'($urandom_range(255));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pulse_maker_multi

// File: doc/pulse_maker_multi.md
PULSE_MAKER_MULTI -- requirements
Module: pulse_maker_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent pulse channels.
REQ-002 SHALL have parameter CNT_W, default 8: width of per-channel delay/width counts.
REQ-003 SHALL have parameter OUT_ACTIVE_LOW, default 1: 1 = out idles high and pulses low; 0 = inverted.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in  input  CHANNELS  trigger inputs, synchronous to clk.
REQ-007 SHALL have port trig_rise  input  CHANNELS  per-channel edge select: 1 = rising edge, 0 = falling edge.
REQ-008 SHALL have port retrig  input  CHANNELS  per-channel mode: 1 = restart on new edge, 0 = ignore it.
REQ-009 SHALL have port delay  input  CHANNELS*CNT_W  per-channel delay in clk cycles; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-010 SHALL have port width  input  CHANNELS*CNT_W  per-channel pulse width in clk cycles, same packing as delay.
REQ-011 SHALL have port out  output  CHANNELS  pulse outputs, registered on the negedge of clk.
REQ-012 SHALL have port busy  output  CHANNELS  high while the channel state is not IDLE; posedge-registered.
REQ-013 SHALL have port overrun  output  CHANNELS  one-cycle high strobe when an edge is ignored; posedge-registered.

Function
REQ-014 Each channel SHALL sample in on every posedge into in_q.
REQ-015 An edge SHALL be detected at posedge k when in at k is the selected level and in_q, sampled at k-1, is the opposite level.
REQ-016 Each channel SHALL run FSM states IDLE, DELAY and PULSE, with a CNT_W-bit down-counter cnt.
REQ-017 Trigger from IDLE at posedge k SHALL capture delay and width into the channel.
REQ-018 If the captured delay > 0, the channel SHALL enter DELAY with cnt = delay-1.
REQ-019 If the captured delay = 0 and width > 0, the channel SHALL enter PULSE with cnt = width-1.
REQ-020 If the captured delay = 0 and width = 0, the channel SHALL stay IDLE.
REQ-021 In DELAY, cnt SHALL decrement on each posedge.
REQ-022 In DELAY with cnt = 0: if width > 0, the channel SHALL go to PULSE with cnt = width-1; if width = 0, it SHALL go to IDLE.
REQ-023 In PULSE, cnt SHALL decrement on each posedge; with cnt = 0, the channel SHALL go to IDLE.
REQ-024 Changes to delay or width after capture SHALL NOT affect the pulse in progress.
REQ-025 out SHALL be updated on each negedge to active when state = PULSE and to inactive otherwise.
REQ-026 Consequence of REQ-025: out asserts at negedge k+delay and stays active for exactly width clk periods.
REQ-027 An edge in DELAY or PULSE with retrig = 1 SHALL restart the channel as if from IDLE (REQ-017 to REQ-020), with fresh capture.
REQ-028 An edge in DELAY or PULSE with retrig = 0 SHALL leave state and cnt unchanged and SHALL raise overrun for one cycle.
REQ-029 An edge on the same posedge the channel returns to IDLE SHALL be treated as an edge in PULSE (REQ-027/REQ-028).
REQ-030 Channels SHALL be fully independent; simultaneous edges on all channels SHALL be handled in the same cycle.
REQ-031 Counters SHALL never wrap: cnt SHALL not decrement below 0.
REQ-032 Maximum delay and width SHALL each be 2^CNT_W-1 cycles.

Reset
REQ-033 While reset = 0 at a posedge: state SHALL become IDLE, cnt 0, busy 0, overrun 0, and in_q <= in, so no spurious edge occurs after release.
REQ-034 While reset = 0 at a negedge, out SHALL go inactive (1 when OUT_ACTIVE_LOW = 1).
REQ-035 Reset asserted mid-DELAY or mid-PULSE SHALL abort the pulse; out SHALL go inactive by the next negedge.

Structure
REQ-036 Package pulse_maker_pkg SHALL hold the FSM state encoding (IDLE = 0, DELAY = 1, PULSE = 2, 2 bits) and the default CNT_W.
REQ-037 One sub-module, pulse_channel (single channel: edge detect, FSM, counter, negedge output flop), SHALL be instantiated CHANNELS times via generate.
REQ-038 The top level SHALL only slice the packed buses and apply OUT_ACTIVE_LOW.

Verification
REQ-039 Scenario: ch0 falling edge, delay = 1, width = 3 -> out[0] low from negedge k+1 to negedge k+4 (3 periods); busy[0] high for 4 cycles.
REQ-040 Scenario: ch1 rising edge, delay = 0, width = 1 -> out[1] low for one period starting at negedge k; delay = 0, width = 0 -> no pulse, busy stays 0.
REQ-041 Scenario: ch2 retrig = 0, delay = 4, width = 2, second edge at k+2 -> overrun[2] high one cycle; pulse at negedge k+4, unchanged.
REQ-042 Scenario: same stimulus as REQ-041 with retrig = 1 -> pulse restarts; out low at negedge k+6 for 2 periods; no overrun.
REQ-043 Scenario: reset = 0 asserted during PULSE with width = 10 -> out inactive at the next negedge; busy 0; no pulse after release with in held constant.
REQ-044 Scenario: all 4 channels triggered on the same posedge with distinct delay/width values -> each pulse matches its own parameters; delay changed mid-DELAY has no effect.
